// File: rtl/dark_frame_ctrl.sv
// Frame-level sequencer for the per-line darkness statistics: line close / vote sampling / per-frame invert decision.
// Optional macro DARK_HYST_EN adds HYST-frame hysteresis on the invert decision.
module dark_frame_ctrl #(
    parameter int LINE_W = 11,
    parameter int LAT    = 2
`ifdef DARK_HYST_EN
    ,
    parameter int HYST   = 3
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vs_i,
    input  logic              hs_i,
    input  logic              de_i,
    input  logic              line_dark_i,
    input  logic [1:0]        force_i,
    output logic              freeze_o,
    output logic              invert_o,
    output logic [LINE_W-1:0] dark_lines_o
);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        ACTIVE  = 2'd1,
        DECIDE  = 2'd2
    } state_t;

    localparam logic [LINE_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]        LAT_V   = 3'(LAT);

    state_t            state, state_d;
    logic              vs_q, hs_q, de_seen;
    logic              pending;
    logic [2:0]        dly;
    logic [LINE_W-1:0] line_cnt, dark_cnt, line_nxt, dark_nxt;
    logic              vs_rise, hs_rise, line_close, take, eval, verdict;
    logic [LINE_W:0]   two_dark;

    assign vs_rise    = vs_i & ~vs_q;
    assign hs_rise    = hs_i & ~hs_q;
    assign line_close = hs_rise & de_seen & (state != WAIT_VS);
    assign take       = pending & (dly == 3'd0);

    // Counts including a sample taken this cycle, so DECIDE can evaluate on the sampling cycle.
    always_comb begin
        line_nxt = line_cnt;
        dark_nxt = dark_cnt;
        if (take) begin
            if (line_cnt != CNT_MAX) line_nxt = line_cnt + 1'b1;
            if (line_dark_i && dark_cnt != CNT_MAX) dark_nxt = dark_cnt + 1'b1;
        end
    end

    assign eval     = (state == DECIDE) && (!pending || take);
    assign two_dark = {dark_nxt, 1'b0};
    assign verdict  = (line_nxt != '0) && (two_dark >= {1'b0, line_nxt});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= WAIT_VS;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            WAIT_VS: if (vs_rise) state_d = ACTIVE;
            ACTIVE:  if (vs_rise) state_d = DECIDE;
            DECIDE:  if (eval)    state_d = ACTIVE;
            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_q     <= 1'b0;
            hs_q     <= 1'b0;
            de_seen  <= 1'b0;
            freeze_o <= 1'b0;
            pending  <= 1'b0;
            dly      <= 3'd0;
        end else begin
            vs_q     <= vs_i;
            hs_q     <= hs_i;
            de_seen  <= hs_rise ? 1'b0 : (de_seen | de_i);
            freeze_o <= line_close;
            if (line_close) begin
                pending <= 1'b1;
                dly     <= LAT_V;
            end else if (take) begin
                pending <= 1'b0;
            end else if (pending) begin
                dly     <= dly - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_cnt     <= '0;
            dark_cnt     <= '0;
            dark_lines_o <= '0;
        end else begin
            case (state)
                WAIT_VS: begin
                    if (vs_rise) begin
                        line_cnt <= '0;
                        dark_cnt <= '0;
                    end
                end
                DECIDE: begin
                    if (eval) begin
                        dark_lines_o <= dark_nxt;
                        line_cnt     <= '0;
                        dark_cnt     <= '0;
                    end else begin
                        line_cnt <= line_nxt;
                        dark_cnt <= dark_nxt;
                    end
                end
                default: begin
                    line_cnt <= line_nxt;
                    dark_cnt <= dark_nxt;
                end
            endcase
        end
    end

`ifdef DARK_HYST_EN
    logic [3:0] hyst_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            invert_o <= 1'b0;
            hyst_cnt <= 4'd0;
        end else begin
            case (force_i)
                2'b01: begin invert_o <= 1'b0; hyst_cnt <= 4'd0; end
                2'b10: begin invert_o <= 1'b1; hyst_cnt <= 4'd0; end
                2'b11: ;
                default: begin
                    // Empty frames carry no verdict and leave the hysteresis untouched.
                    if (eval && line_nxt != '0) begin
                        if (verdict != invert_o) begin
                            if (hyst_cnt + 4'd1 == 4'(HYST)) begin
                                invert_o <= ~invert_o;
                                hyst_cnt <= 4'd0;
                            end else begin
                                hyst_cnt <= hyst_cnt + 4'd1;
                            end
                        end else begin
                            hyst_cnt <= 4'd0;
                        end
                    end
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            invert_o <= 1'b0;
        end else begin
            case (force_i)
                2'b01:   invert_o <= 1'b0;
                2'b10:   invert_o <= 1'b1;
                2'b11:   ;
                default: if (eval && line_nxt != '0) invert_o <= verdict;
            endcase
        end
    end
`endif

endmodule

// File: doc/dark_frame_ctrl.md
# dark_frame_ctrl

Frame-level sequencer for the per-line darkness statistics path. Detects line and frame boundaries from the HDMI timing signals, issues the one-cycle freeze pulse that closes each line's statistics buffer, collects the resulting per-line dark vote, and at every vertical sync decides whether the next frame is inverted. It sits between the video timing input and the line buffers, and drives the invert select consumed by the pixel datapath.

## Interface
- `LINE_W`, default 11: width of the line and dark-line counters. Both saturate at 2^LINE_W-1.
- `LAT`, default 2: cycles from `freeze_o` until `line_dark_i` is valid. Range 1..7.
- `HYST`, default 3: consecutive disagreeing frame verdicts required to flip `invert_o`. Range 1..15.
- `clk_i` in 1: pixel clock.
- `rst_ni` in 1: reset. Asynchronous assert, active-low.
- `vs_i` in 1: vertical sync, active-high.
- `hs_i` in 1: horizontal sync, active-high.
- `de_i` in 1: data enable.
- `line_dark_i` in 1: per-line dark vote from the line buffer.
- `force_i` in 2: invert control. 00 selects auto. 01 forces off. 10 forces on. 11 holds the current value.
- `freeze_o` out 1: one-cycle line-close pulse to the line buffers.
- `invert_o` out 1: registered invert decision.
- `dark_lines_o` out LINE_W: dark-line count of the last completed frame.

## Operation
- Edge detection: `vs_i` and `hs_i` are registered once. A rise is the current input at 1 while the registered copy is 0.
- `de_seen` flag:
  - Set by `de_i`.
  - Cleared on each hs rise.
  - Blank lines (no `de_i` between hs rises) produce no freeze, no sample and no count.
- Line close: an hs rise with `de_seen`=1 asserts `freeze_o` for exactly 1 cycle, registered on the next edge. It also loads the sample delay counter with `LAT`.
- Sample: when the delay counter reaches 0 with a sample pending:
  - `line_cnt` increments.
  - `dark_cnt` increments if `line_dark_i`=1.
  - Both counters saturate and never wrap.
- States:
  - WAIT_VS (reset state): the first, partial frame is ignored. No freeze or counting. On vs rise, clear the counters and go to ACTIVE.
  - ACTIVE: line processing as above. On vs rise, go to DECIDE.
  - DECIDE:
    - Wait until no sample is pending, then evaluate for 1 cycle.
    - Verdict: dark = (`line_cnt`≠0) and (2·`dark_cnt` ≥ `line_cnt`). Use LINE_W+1-bit arithmetic.
    - `dark_lines_o` ← `dark_cnt`.
    - Clear both counters, then go to ACTIVE.
    - A frame with `line_cnt`=0 leaves `invert_o` and the hysteresis counter unchanged.
    - An hs rise arriving while in DECIDE is handled as in ACTIVE; its line counts toward the new frame.
- Force handling:
  - `force_i`=01 or 10 sets `invert_o` to 0 or 1 on the next edge and clears the hysteresis counter.
  - `force_i`=11 freezes both `invert_o` and the hysteresis counter.
  - `force_i`=00 applies the verdict as described under Configuration.
  - Force does not stop line processing.
- Reset mid-frame: all state clears immediately and operation restarts in WAIT_VS.

## Timing
- Reset values:
  - `freeze_o`=0, `invert_o`=0, `dark_lines_o`=0.
  - State WAIT_VS; counters 0; hysteresis counter 0.
- `freeze_o` rises 1 cycle after the cycle in which `hs_i` is first seen high (2 edges after the input transition).
- The sample is taken `LAT` cycles after the `freeze_o` cycle.
- Simultaneous hs and vs rise:
  - The line close is processed first and is counted in the ending frame.
  - DECIDE waits until that line's sample has been taken.
- `invert_o` and `dark_lines_o` update on the edge that ends the DECIDE evaluation cycle. Latency from vs rise is at least 2 cycles, longer only when DECIDE waits for a pending sample.
- `invert_o` changes at most once per frame in auto mode.

## Configuration
- `DARK_HYST_EN` defined:
  - A verdict different from `invert_o` increments the hysteresis counter.
  - A verdict equal to `invert_o` clears it.
  - When the count reaches `HYST`, `invert_o` flips and the counter clears.
- `DARK_HYST_EN` undefined:
  - `invert_o` takes the verdict directly at each DECIDE.
  - The `HYST` parameter and hysteresis counter are absent.

## Test plan
- Startup: reset, then 3 frames of 10 lines each with all `line_dark_i`=1, `force_i`=00.
  - The first partial frame is ignored.
  - `dark_lines_o`=10 after frame 2.
  - `invert_o`=1 after the 3rd decided frame with `DARK_HYST_EN` and `HYST`=3; after the 1st decided frame without it.
- Majority boundary, 10 lines:
  - 5 dark lines → verdict dark.
  - 4 dark lines → verdict light.
- Boundary coincidence: hs and vs rise on the same cycle with `LAT`=2. The last line is counted in the ending frame, and the decision waits 2 extra cycles.
- Blank lines: 3 lines with no `de_i` produce no `freeze_o` pulses, and `line_cnt` is unchanged.
- Force override:
  - Setting `force_i`=10 mid-frame gives `invert_o`=1 on the next edge.
  - Setting `force_i`=11 then holds `invert_o` through 2 all-light frames.
- Reset mid-frame: assert `rst_ni`=0 during line 5. All outputs go to 0 asynchronously, and the next frame is ignored (WAIT_VS).
